// File: rtl/stack_op_sequencer.sv
// Pops one or two operands from the operand stack, hands them to the ALU over a
// valid/ready handshake, then pushes the ALU result back with the ALU source selected.
module stack_op_sequencer #(
    parameter int DATA_W = 8,
    parameter int PTR_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              unary,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic [PTR_W-1:0]  stk_tos,
    output logic              stk_pop,
    input  logic [DATA_W-1:0] stk_dout,
    output logic              stk_push,
    output logic              stk_sel,
    output logic [DATA_W-1:0] stk_din,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic              alu_valid,
    input  logic              alu_ready,
    input  logic [DATA_W-1:0] alu_result
);

    // state  | meaning
    // IDLE   | waiting for start; ERR: underflow reported | POP_B/WAIT_B: top entry -> B
    // POP_A/WAIT_A: next entry -> A | EXEC: operands offered to ALU | PUSH: result written back
    typedef enum logic [2:0] {
        S_IDLE,
        S_ERR,
        S_POP_B,
        S_WAIT_B,
        S_POP_A,
        S_WAIT_A,
        S_EXEC,
        S_PUSH
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [DATA_W-1:0]   r_res;
    logic                r_err;
    logic [PTR_W-1:0]    w_need;
    logic                w_underflow;

    assign w_need      = unary ? PTR_W'(1) : PTR_W'(2);
    assign w_underflow = (stk_tos < w_need);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_underflow)
                        w_next = S_ERR;
                    else if (unary)
                        w_next = S_POP_A;
                    else
                        w_next = S_POP_B;
                end
            end
            S_ERR:    w_next = S_IDLE;
            S_POP_B:  w_next = S_WAIT_B;
            S_WAIT_B: w_next = S_POP_A;
            S_POP_A:  w_next = S_WAIT_A;
            S_WAIT_A: w_next = S_EXEC;
            S_EXEC: begin
                if (alu_ready)
                    w_next = S_PUSH;
            end
            S_PUSH:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_err   <= (w_next == S_ERR);
            case (r_state)
                S_IDLE: begin
                    // Unary ops present a zero B operand.
                    if (start && !w_underflow && unary)
                        r_b <= '0;
                end
                S_WAIT_B: r_b <= stk_dout;
                S_WAIT_A: r_a <= stk_dout;
                S_EXEC: begin
                    if (alu_ready)
                        r_res <= alu_result;
                end
                default: ;
            endcase
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign stk_pop   = (r_state == S_POP_B) || (r_state == S_POP_A);
    assign alu_valid = (r_state == S_EXEC);
    assign stk_push  = (r_state == S_PUSH);
    assign stk_sel   = (r_state == S_PUSH);
    assign done      = (r_state == S_PUSH);
    assign err       = r_err;
    assign alu_a     = r_a;
    assign alu_b     = r_b;
    assign stk_din   = r_res;

endmodule

// File: tb/tb_stack_op_sequencer.sv
// Directed bench for stack_op_sequencer: behavioural stack, scoreboard queues for
// ALU operands and pushed results, cycle-exact checks of the control strobes.
module tb_stack_op_sequencer;

    localparam int DW = 8;
    localparam int PW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          unary;
    logic          busy;
    logic          done;
    logic          err;
    logic [PW-1:0] stk_tos;
    logic          stk_pop;
    logic [DW-1:0] stk_dout;
    logic          stk_push;
    logic          stk_sel;
    logic [DW-1:0] stk_din;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic          alu_valid;
    logic          alu_ready;
    logic [DW-1:0] alu_result;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;

    logic [DW-1:0]  q_res[$];
    logic [2*DW-1:0] q_ops[$];

    // stack model
    logic [DW-1:0] mem [0:15];
    logic [PW-1:0] sp = '0;
    logic          clr;
    logic          ld_en;
    logic [DW-1:0] ld_val;

    assign stk_tos = sp;

    always #5 clk = ~clk;

    stack_op_sequencer #(.DATA_W(DW), .PTR_W(PW)) dut (
        .clk(clk), .rst(rst), .start(start), .unary(unary),
        .busy(busy), .done(done), .err(err),
        .stk_tos(stk_tos), .stk_pop(stk_pop), .stk_dout(stk_dout),
        .stk_push(stk_push), .stk_sel(stk_sel), .stk_din(stk_din),
        .alu_a(alu_a), .alu_b(alu_b), .alu_valid(alu_valid),
        .alu_ready(alu_ready), .alu_result(alu_result)
    );

    always @(posedge clk) begin
        if (clr)
            sp <= '0;
        else if (ld_en) begin
            mem[sp[3:0]] <= ld_val;
            sp <= sp + 1'b1;
        end else if (stk_pop && sp != 0) begin
            stk_dout <= mem[sp[3:0] - 4'd1];
            sp <= sp - 1'b1;
        end else if (stk_push) begin
            mem[sp[3:0]] <= stk_din;
            sp <= sp + 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_ctl"}, {busy, done, err, stk_pop, stk_push, stk_sel, alu_valid}, 0);
    endtask

    task automatic chk_zero(input string tag);
        chk_quiet(tag);
        chk({tag, "_data"}, {alu_a, alu_b, stk_din}, 0);
    endtask

    task automatic load(input logic [DW-1:0] v);
        ld_en = 1'b1;
        ld_val = v;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic clear_stack();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    // scoreboard side: pushes and ALU accepts
    always @(negedge clk) begin
        logic [DW-1:0]   r_exp;
        logic [2*DW-1:0] o_exp;
        if (!rst) begin
            if (stk_pop || stk_push)
                chk("pop_push_excl", {31'd0, stk_pop & stk_push}, 0);
            if (stk_push || done) begin
                done_cnt++;
                chk("push_expected", {31'd0, q_res.size() != 0}, 1);
                chk("done_with_push", {31'd0, done}, {31'd0, stk_push});
                chk("sel_with_push", {31'd0, stk_sel}, 1);
                if (q_res.size() != 0) begin
                    r_exp = q_res.pop_front();
                    chk("push_data", {24'd0, stk_din}, {24'd0, r_exp});
                end
            end
            if (alu_valid && alu_ready) begin
                chk("accept_expected", {31'd0, q_ops.size() != 0}, 1);
                if (q_ops.size() != 0) begin
                    o_exp = q_ops.pop_front();
                    chk("alu_operands", {16'd0, alu_a, alu_b}, {16'd0, o_exp});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; unary = 1'b0;
        alu_ready = 1'b1; alu_result = '0;
        clr = 1'b1; ld_en = 1'b0; ld_val = '0;
        tick(); tick();
        chk_zero("reset_hold");
        rst = 1'b0; clr = 1'b0;
        tick(); tick();
        chk_zero("idle_after_reset");

        // asynchronous reset while popping
        load(8'h03); load(8'h05);
        start = 1'b1; unary = 1'b0;
        tick();
        start = 1'b0;
        chk("async_pre_pop", {31'd0, stk_pop}, 1);
        #3 rst = 1'b1;
        #1 chk_zero("async_reset");
        tick();
        rst = 1'b0;
        tick();
        chk_quiet("async_release");
        chk("async_depth", {16'd0, sp}, 2);

        // binary op, stack 3 then 5
        alu_result = 8'd8;
        q_res.push_back(8'd8);
        q_ops.push_back({8'd3, 8'd5});
        start = 1'b1; unary = 1'b0;
        tick(); start = 1'b0;
        chk("bin_c1", {busy, stk_pop, stk_push, alu_valid}, 4'b1100);
        tick();
        chk("bin_c2", {busy, stk_pop, stk_push, alu_valid}, 4'b1000);
        tick();
        chk("bin_c3", {busy, stk_pop, stk_push, alu_valid}, 4'b1100);
        tick();
        chk("bin_c4", {busy, stk_pop, stk_push, alu_valid}, 4'b1000);
        tick();
        chk("bin_c5", {busy, stk_pop, alu_valid, alu_a, alu_b}, {3'b101, 8'd3, 8'd5});
        tick();
        chk("bin_c6", {stk_push, stk_sel, done, stk_din}, {3'b111, 8'd8});
        tick();
        chk_quiet("bin_c7");
        chk("bin_depth", {16'd0, sp}, 1);

        // unary op, stack holds 0x0F
        clear_stack();
        load(8'h0F);
        alu_result = 8'hF0;
        q_res.push_back(8'hF0);
        q_ops.push_back({8'h0F, 8'h00});
        start = 1'b1; unary = 1'b1;
        tick(); start = 1'b0; unary = 1'b0;
        chk("un_c1", {busy, stk_pop, alu_valid}, 3'b110);
        tick();
        chk("un_c2", {busy, stk_pop, alu_valid}, 3'b100);
        tick();
        chk("un_c3", {alu_valid, alu_a, alu_b}, {1'b1, 8'h0F, 8'h00});
        tick();
        chk("un_c4", {stk_push, stk_sel, done, stk_din}, {3'b111, 8'hF0});
        tick();
        chk_quiet("un_c5");
        chk("un_depth", {16'd0, sp}, 1);

        // underflow: binary with one entry, then unary with none
        start = 1'b1; unary = 1'b0;
        tick(); start = 1'b0;
        chk("uf_bin_c1", {err, stk_pop, stk_push, done}, 4'b1000);
        tick();
        chk_quiet("uf_bin_c2");
        chk("uf_bin_depth", {16'd0, sp}, 1);
        clear_stack();
        start = 1'b1; unary = 1'b1;
        tick(); start = 1'b0; unary = 1'b0;
        chk("uf_un_c1", {err, stk_pop, stk_push, done}, 4'b1000);
        tick();
        chk_quiet("uf_un_c2");
        chk("uf_un_depth", {16'd0, sp}, 0);

        // ALU backpressure with ignored start pulses
        load(8'h11); load(8'h22);
        alu_ready = 1'b0;
        q_res.push_back(8'h5C);
        q_ops.push_back({8'h11, 8'h22});
        start = 1'b1; unary = 1'b0;
        tick(); start = 1'b0;
        tick(); tick(); tick(); tick();
        for (int i = 0; i < 4; i++) begin
            alu_result = 8'hA0 + 8'(i);
            start = (i == 1);
            chk("bp_hold", {alu_valid, stk_push, alu_a, alu_b}, {2'b10, 8'h11, 8'h22});
            tick();
        end
        start = 1'b0;
        alu_ready = 1'b1; alu_result = 8'h5C;
        chk("bp_accept", {31'd0, alu_valid}, 1);
        tick();
        alu_ready = 1'b0; alu_result = 8'h00;
        chk("bp_push", {stk_push, done, stk_din}, {2'b11, 8'h5C});
        tick();
        chk_quiet("bp_idle");
        tick();
        chk_quiet("bp_no_requeue");
        chk("bp_depth", {16'd0, sp}, 1);
        alu_ready = 1'b1;

        // reset during WAIT_A, then a clean op
        clear_stack();
        load(8'h01); load(8'h02);
        start = 1'b1; unary = 1'b0;
        tick(); start = 1'b0;
        tick(); tick(); tick();
        chk("abort_wait_a", {busy, stk_pop, alu_valid}, 3'b100);
        #3 rst = 1'b1;
        #1 chk_zero("abort_reset");
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk_quiet("abort_idle");
        chk("abort_depth", {16'd0, sp}, 0);

        load(8'h04); load(8'h06);
        alu_result = 8'h0A;
        q_res.push_back(8'h0A);
        q_ops.push_back({8'h04, 8'h06});
        start = 1'b1; unary = 1'b0;
        tick(); start = 1'b0;
        tick(); tick(); tick(); tick();
        chk("post_c5", {alu_valid, alu_a, alu_b}, {1'b1, 8'h04, 8'h06});
        tick();
        chk("post_c6", {stk_push, done, stk_din}, {2'b11, 8'h0A});
        tick();
        chk_quiet("post_c7");

        tick();
        chk("res_queue_empty", q_res.size(), 0);
        chk("ops_queue_empty", q_ops.size(), 0);
        chk("done_count", done_cnt, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stack_op_sequencer.md
Name: stack_op_sequencer

Overview:
- Stack-side consumer for the stack-based datapath; the reader counterpart to the stack's push path.
- On a request from the control unit (UC), it pops one or two operands from the operand stack and presents them to the ALU (ULA) with a valid/ready handshake.
- It pushes the ALU result back onto the stack with the ALU source selected.
- It checks stack depth before touching the stack. On underflow it reports an error and performs no stack operation.

Parameters:
- DATA_W, 8, width of stack entries, ALU operands and result.
- PTR_W, 16, width of the stack top-of-stack index.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  UC request, sampled only in IDLE.
- unary  input  1  sampled with start; 1 = one-operand op, 0 = two-operand op.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse: result push is being issued this cycle.
- err  output  1  one-cycle pulse: request rejected for stack underflow.
- stk_tos  input  PTR_W  current stack occupancy (number of valid entries).
- stk_pop  output  1  one-cycle pop strobe to the stack.
- stk_dout  input  DATA_W  popped data; valid the cycle after stk_pop.
- stk_push  output  1  one-cycle push strobe to the stack.
- stk_sel  output  1  stack write-source select; 1 = ALU path, driven high with stk_push.
- stk_din  output  DATA_W  data to push (the ALU result).
- alu_a  output  DATA_W  first operand (deeper stack entry).
- alu_b  output  DATA_W  second operand (top entry); 0 for unary ops.
- alu_valid  output  1  operands valid; held until accepted.
- alu_ready  input  1  ALU accepts; alu_result is valid in the same cycle.
- alu_result  input  DATA_W  ALU output, sampled when alu_valid & alu_ready.

Behaviour:
- Reset (asynchronous):
  - State goes to IDLE.
  - busy, done, err, stk_pop, stk_push, stk_sel and alu_valid are all 0.
  - alu_a, alu_b, stk_din and the operand/result registers are all 0.
- Output decoding:
  - All strobes (stk_pop, stk_push, stk_sel, alu_valid, done) decode from the registered state (Moore), so they are glitch-free.
  - err is registered.
- States: IDLE, ERR, POP_B, WAIT_B, POP_A, WAIT_A, EXEC, PUSH.
- IDLE, on start=1, with need = 1 if unary else 2:
  - stk_tos < need: go to ERR. err=1 for exactly that cycle, then back to IDLE. No pop or push is issued.
  - Otherwise, binary: go to POP_B.
  - Otherwise, unary: clear alu_b to 0 and go to POP_A.
  - unary is latched at the start edge.
- POP_B: stk_pop=1, then WAIT_B.
- WAIT_B: capture stk_dout into the B register at the end of the cycle, then POP_A.
- POP_A: stk_pop=1, then WAIT_A.
- WAIT_A: capture stk_dout into the A register, then EXEC.
- EXEC:
  - alu_valid=1, with alu_a/alu_b stable.
  - Stay in EXEC while alu_ready=0.
  - On alu_ready=1, capture alu_result into the result register and go to PUSH.
- PUSH:
  - stk_push=1, stk_sel=1, stk_din = result register, done=1.
  - Go to IDLE next cycle.
- Latency with alu_ready tied high (start sampled in cycle 0):
  - Binary: pops in cycles 1 and 3; alu_valid in cycle 5; push and done in cycle 6.
  - Unary: pop in cycle 1; alu_valid in cycle 3; push and done in cycle 4.
- Operand ordering: the first pop is the top of stack and goes to B; the second pop goes to A. So for a stack holding x then y (y on top), the ALU sees a=x, b=y.
- start while busy is ignored, not queued.
- Net stack effect:
  - Binary: -1 entry.
  - Unary: 0 entries.
  - Error: 0 entries.
  - Overflow is therefore impossible, and no full check is made.
- At most one of stk_pop / stk_push is high in any cycle.
- Reset mid-operation: the FSM aborts to IDLE immediately. Entries already popped are lost and not restored. No push or done is issued. The UC must reinitialise the stack after reset.
- stk_tos is only examined in IDLE. Changes during an operation are not checked.
- Width rules: no arithmetic on data; the result is passed through unmodified. Depth comparison is unsigned, at PTR_W bits.

Test Plan:
- Reset: assert rst mid-cycle (asynchronous) -> all outputs 0 immediately, busy=0; release -> stays IDLE with start=0.
- Binary op: stack holds 3 then 5 (stk_tos=2), start with unary=0, alu_ready=1, alu_result=8 -> stk_pop in cycles 1 and 3; alu_a=3, alu_b=5, alu_valid in cycle 5; stk_push=1, stk_sel=1, stk_din=8, done=1 in cycle 6; busy=0 in cycle 7.
- Unary op: stack holds 0x0F, start with unary=1, alu_result=0xF0 -> one pop; alu_a=0x0F, alu_b=0 in cycle 3; push 0xF0 with done in cycle 4.
- Underflow: stk_tos=1, binary start -> err=1 in cycle 1 only; no stk_pop/stk_push; busy low again in cycle 2. Repeat with stk_tos=0 and unary=1 -> same result.
- ALU backpressure: alu_ready=0 for 4 cycles in EXEC -> alu_valid stays high with stable operands; push occurs one cycle after alu_ready rises, carrying the result sampled on the accept cycle; start pulses during busy are ignored.
- Reset in WAIT_A of a binary op -> immediate IDLE; no push or done ever appears; the next start proceeds normally.
